// File: rtl/fpnew_noncomp_wb.sv
// fpnew_noncomp_wb: packs non-comp FP results to FLEN and buffers them in a 2-deep FIFO.
// Define FPNEW_NONCOMP_WB_FFLAGS_EN to build the sticky fflags register.
module fpnew_noncomp_wb #(
    parameter logic [2:0]  FpFormat = 3'd0,
    parameter int unsigned FLEN     = 64,
    parameter type         TagType  = logic,
    localparam int unsigned WIDTH = (FpFormat == 3'd0) ? 32 : (FpFormat == 3'd1) ? 64 :
                                    (FpFormat == 3'd3) ? 8 : 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] result_i,
    input  logic [4:0]       status_i,
    input  logic             extension_bit_i,
    input  logic [9:0]       class_mask_i,
    input  logic             is_class_i,
    input  TagType           tag_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [FLEN-1:0]  wb_data_o,
    output logic [4:0]       wb_status_o,
    output TagType           wb_tag_o,
    output logic [4:0]       fflags_o,
    input  logic             fflags_clr_i,
    output logic             busy_o
);
    if (FLEN < WIDTH || FLEN < 10) begin : g_bad_flen
        $error("fpnew_noncomp_wb: FLEN must be >= WIDTH and >= 10");
    end

    logic [FLEN-1:0] data_q [2];
    logic [4:0]      status_q [2];
    TagType          tag_q [2];
    logic            wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [FLEN-1:0] packed_data;
    logic            push, pop;

    assign in_ready_o  = (cnt_q != 2'd2) && !flush_i;
    assign out_valid_o = (cnt_q != 2'd0);
    assign busy_o      = out_valid_o;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;
    assign wb_data_o   = data_q[rptr_q];
    assign wb_status_o = status_q[rptr_q];
    assign wb_tag_o    = tag_q[rptr_q];

    // Fill the whole word first so FLEN == WIDTH needs no special case.
    always_comb begin
        packed_data = '0;
        if (is_class_i) begin
            packed_data[9:0] = class_mask_i;
        end else begin
            packed_data = {FLEN{extension_bit_i}};
            packed_data[WIDTH-1:0] = result_i;
        end
    end

    always_comb begin
        wptr_d = flush_i ? 1'b0 : wptr_q ^ push;
        rptr_d = flush_i ? 1'b0 : rptr_q ^ pop;
        cnt_d  = flush_i ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            cnt_q    <= 2'd0;
            data_q   <= '{default: '0};
            status_q <= '{default: '0};
            tag_q    <= '{default: '0};
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            if (push) begin
                data_q[wptr_q]   <= packed_data;
                status_q[wptr_q] <= status_i;
                tag_q[wptr_q]    <= tag_i;
            end
        end
    end

`ifdef FPNEW_NONCOMP_WB_FFLAGS_EN
    logic [4:0] fflags_q, fflags_d;
    // A pop during a flush still retires its beat, so its flags count.
    assign fflags_d = (fflags_clr_i ? 5'd0 : fflags_q) | (pop ? wb_status_o : 5'd0);
    assign fflags_o = fflags_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) fflags_q <= 5'd0;
        else         fflags_q <= fflags_d;
    end
`else
    logic unused_fflags_clr;
    assign unused_fflags_clr = fflags_clr_i;
    assign fflags_o = 5'd0;
`endif
endmodule
